// File: rtl/reg_bus_host_bridge_if.sv
// Host bridge signal bundle: host byte stream in/out plus the 14-bit register bus.
// The bridge uses the master modport; the host/slave side uses the slave modport.
interface reg_bus_host_bridge_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [13:0] adr;
  logic        we;
  logic [7:0]  dat_w;
  logic [7:0]  dat_r;
  logic        chk_err;

  modport master (
    input  rx_data, rx_valid, tx_ready, dat_r,
    output rx_ready, tx_data, tx_valid, adr, we, dat_w, chk_err
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, dat_r,
    input  rx_ready, tx_data, tx_valid, adr, we, dat_w, chk_err
  );
endinterface

// File: rtl/reg_bus_host_bridge.sv
// Host-side register bus master. Parses SYNC/HDR/LO/[DATA]/CHK packets from the
// host byte stream, performs one bus write or read, and answers with ACK, NACK
// or ACK followed by the read byte. All outputs come straight from registers.
module reg_bus_host_bridge #(
  parameter int unsigned TIMEOUT = 1023,
  parameter logic [7:0]  SYNC    = 8'h55,
  parameter logic [7:0]  ACK     = 8'hAA,
  parameter logic [7:0]  NACK    = 8'hEE
) (
  input  logic                        clk,
  input  logic                        rst,
  reg_bus_host_bridge_if.master       bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_LO,
    S_DATA,
    S_CHK,
    S_BUS_W,
    S_BUS_R,
    S_BUS_RWAIT,
    S_RESP0,
    S_RESP1
  } state_t;

  // Idle-count value at which one more silent cycle means TIMEOUT has been reached.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_t      state_reg;
  logic        rx_ready_reg;
  logic [7:0]  tx_data_reg;
  logic        tx_valid_reg;
  logic [13:0] adr_reg;
  logic        we_reg;
  logic [7:0]  dat_w_reg;
  logic        chk_err_reg;

  logic        is_read_reg;    // rw bit of the packet being parsed
  logic [5:0]  adr_hi_reg;     // HDR[5:0]; HDR[6] only contributes to the checksum
  logic [7:0]  adr_lo_reg;
  logic [7:0]  data_reg;
  logic [7:0]  sum_reg;        // running checksum over HDR, LO, DATA
  logic [7:0]  rd_reg;         // captured read data for RESP1
  logic        resp_read_reg;  // response is ACK followed by read data
  logic [15:0] idle_cnt_reg;

  logic rx_fire;
  logic tx_fire;
  logic collecting;

  assign rx_fire    = bus.rx_valid && rx_ready_reg;
  assign tx_fire    = tx_valid_reg && bus.tx_ready;
  assign collecting = (state_reg == S_HDR) || (state_reg == S_LO) ||
                      (state_reg == S_DATA) || (state_reg == S_CHK);

  assign bus.rx_ready = rx_ready_reg;
  assign bus.tx_data  = tx_data_reg;
  assign bus.tx_valid = tx_valid_reg;
  assign bus.adr      = adr_reg;
  assign bus.we       = we_reg;
  assign bus.dat_w    = dat_w_reg;
  assign bus.chk_err  = chk_err_reg;

  // Packet parser, bus sequencer and response FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      rx_ready_reg  <= 1'b0;
      tx_data_reg   <= 8'h00;
      tx_valid_reg  <= 1'b0;
      adr_reg       <= 14'h0000;
      we_reg        <= 1'b0;
      dat_w_reg     <= 8'h00;
      chk_err_reg   <= 1'b0;
      is_read_reg   <= 1'b0;
      adr_hi_reg    <= 6'h00;
      adr_lo_reg    <= 8'h00;
      data_reg      <= 8'h00;
      sum_reg       <= 8'h00;
      rd_reg        <= 8'h00;
      resp_read_reg <= 1'b0;
      idle_cnt_reg  <= 16'h0000;
    end else begin
      we_reg      <= 1'b0;
      chk_err_reg <= 1'b0;

      // Inter-byte idle counter: cleared by every accepted byte.
      if (rx_fire) begin
        idle_cnt_reg <= 16'h0000;
      end else if (collecting) begin
        idle_cnt_reg <= idle_cnt_reg + 16'd1;
      end

      case (state_reg)
        S_IDLE: begin
          rx_ready_reg <= 1'b1;
          if (rx_fire && (bus.rx_data == SYNC)) begin
            state_reg <= S_HDR;
          end
        end

        S_HDR: begin
          if (rx_fire) begin
            is_read_reg <= bus.rx_data[7];
            adr_hi_reg  <= bus.rx_data[5:0];
            sum_reg     <= bus.rx_data;
            state_reg   <= S_LO;
          end
        end

        S_LO: begin
          if (rx_fire) begin
            adr_lo_reg <= bus.rx_data;
            sum_reg    <= sum_reg + bus.rx_data;
            state_reg  <= is_read_reg ? S_CHK : S_DATA;
          end
        end

        S_DATA: begin
          if (rx_fire) begin
            data_reg  <= bus.rx_data;
            sum_reg   <= sum_reg + bus.rx_data;
            state_reg <= S_CHK;
          end
        end

        S_CHK: begin
          if (rx_fire) begin
            rx_ready_reg <= 1'b0;
            if (bus.rx_data == sum_reg) begin
              adr_reg       <= {adr_hi_reg, adr_lo_reg};
              resp_read_reg <= is_read_reg;
              if (is_read_reg) begin
                state_reg <= S_BUS_R;
              end else begin
                dat_w_reg <= data_reg;
                we_reg    <= 1'b1;
                state_reg <= S_BUS_W;
              end
            end else begin
              chk_err_reg   <= 1'b1;
              tx_data_reg   <= NACK;
              tx_valid_reg  <= 1'b1;
              resp_read_reg <= 1'b0;
              state_reg     <= S_RESP0;
            end
          end
        end

        S_BUS_W: begin
          tx_data_reg  <= ACK;
          tx_valid_reg <= 1'b1;
          state_reg    <= S_RESP0;
        end

        S_BUS_R: begin
          state_reg <= S_BUS_RWAIT;
        end

        S_BUS_RWAIT: begin
          rd_reg       <= bus.dat_r;
          tx_data_reg  <= ACK;
          tx_valid_reg <= 1'b1;
          state_reg    <= S_RESP0;
        end

        S_RESP0: begin
          if (tx_fire) begin
            if (resp_read_reg) begin
              tx_data_reg <= rd_reg;
              state_reg   <= S_RESP1;
            end else begin
              tx_valid_reg <= 1'b0;
              rx_ready_reg <= 1'b1;
              state_reg    <= S_IDLE;
            end
          end
        end

        S_RESP1: begin
          if (tx_fire) begin
            tx_valid_reg <= 1'b0;
            rx_ready_reg <= 1'b1;
            state_reg    <= S_IDLE;
          end
        end

        default: begin
          tx_valid_reg <= 1'b0;
          rx_ready_reg <= 1'b0;
          state_reg    <= S_IDLE;
        end
      endcase

      // A stalled packet is dropped silently once the idle count reaches TIMEOUT.
      if (collecting && !rx_fire && (idle_cnt_reg == TIMEOUT_LAST)) begin
        state_reg    <= S_IDLE;
        idle_cnt_reg <= 16'h0000;
      end
    end
  end

endmodule

// File: tb/tb_reg_bus_host_bridge.sv
// Directed bench for reg_bus_host_bridge: write, read, reserved header bit,
// bad checksum, junk/timeout, backpressure and mid-packet reset.
module tb_reg_bus_host_bridge;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_bus_host_bridge_if bus();

  reg_bus_host_bridge #(
    .TIMEOUT(TO),
    .SYNC(8'h55),
    .ACK(8'hAA),
    .NACK(8'hEE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int chk_cnt = 0;
  logic [13:0] last_adr = 14'h0;
  logic [7:0]  last_dw = 8'h0;
  logic [7:0]  tx_q[$];

  // Register slave model: registers read data one edge after seeing the address.
  always @(posedge clk) begin
    if (!bus.we) begin
      bus.dat_r <= (bus.adr == 14'h0512) ? 8'h3C : (bus.adr[7:0] ^ 8'hA5);
    end
  end

  // Bus and response monitors.
  always @(posedge clk) begin
    if (bus.we) begin
      we_cnt   <= we_cnt + 1;
      last_adr <= bus.adr;
      last_dw  <= bus.dat_w;
    end
    if (bus.chk_err) chk_cnt <= chk_cnt + 1;
    if (!rst && bus.tx_valid && bus.tx_ready) tx_q.push_back(bus.tx_data);
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    n = 0;
    while (!bus.rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL send_byte_timeout: byte %h not accepted, rx_ready=%b required 1", b, bus.rx_ready);
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int base, input int n, input string name);
    int k;
    k = 0;
    while (tx_q.size() < base + n && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (tx_q.size() !== base + n) begin
      errors++;
      $display("FAIL %s_resp_count: got %0d bytes, required %0d", name, tx_q.size() - base, n);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.adr, bus.we, bus.dat_w, bus.tx_valid, bus.tx_data, bus.chk_err, bus.rx_ready} !== 34'h0) begin
      errors++;
      $display("FAIL reset_values: adr=%h we=%b dat_w=%h tx_valid=%b tx_data=%h chk_err=%b rx_ready=%b, required all 0",
               bus.adr, bus.we, bus.dat_w, bus.tx_valid, bus.tx_data, bus.chk_err, bus.rx_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_rx_ready: rx_ready=%b required 1", bus.rx_ready);
    end
    $display("reset: outputs cleared, rx_ready=%b", bus.rx_ready);
  endtask

  task automatic test_write;
    int w0, c0, t0;
    w0 = we_cnt; c0 = chk_cnt; t0 = tx_q.size();
    send_byte(8'h55); send_byte(8'h05); send_byte(8'h12); send_byte(8'h3C); send_byte(8'h53);
    checks++;
    if ({bus.we, bus.adr, bus.dat_w} !== {1'b1, 14'h0512, 8'h3C}) begin
      errors++;
      $display("FAIL write_strobe: we=%b adr=%h dat_w=%h, required 1/0512/3c", bus.we, bus.adr, bus.dat_w);
    end
    checks++;
    if (bus.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL write_ack_early: tx_valid=%b required 0", bus.tx_valid);
    end
    @(negedge clk);
    checks++;
    if ({bus.we, bus.tx_valid, bus.tx_data} !== {1'b0, 1'b1, 8'hAA}) begin
      errors++;
      $display("FAIL write_ack: we=%b tx_valid=%b tx_data=%h, required 0/1/aa", bus.we, bus.tx_valid, bus.tx_data);
    end
    wait_tx(t0, 1, "write");
    checks++;
    if (tx_q[t0] !== 8'hAA) begin
      errors++;
      $display("FAIL write_resp: got %h required aa", tx_q[t0]);
    end
    checks++;
    if (we_cnt - w0 !== 1 || chk_cnt - c0 !== 0) begin
      errors++;
      $display("FAIL write_pulses: we pulses=%0d chk_err pulses=%0d, required 1/0", we_cnt - w0, chk_cnt - c0);
    end
    $display("write: adr=%h dat_w=%h resp=%h", last_adr, last_dw, tx_q[t0]);
  endtask

  task automatic test_read;
    int w0, t0;
    w0 = we_cnt; t0 = tx_q.size();
    send_byte(8'h55); send_byte(8'h85); send_byte(8'h12); send_byte(8'h97);
    checks++;
    if ({bus.we, bus.adr} !== {1'b0, 14'h0512}) begin
      errors++;
      $display("FAIL read_addr: we=%b adr=%h, required 0/0512", bus.we, bus.adr);
    end
    @(negedge clk);
    checks++;
    if (bus.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_ack_early: tx_valid=%b required 0", bus.tx_valid);
    end
    @(negedge clk);
    checks++;
    if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'hAA}) begin
      errors++;
      $display("FAIL read_ack: tx_valid=%b tx_data=%h, required 1/aa", bus.tx_valid, bus.tx_data);
    end
    @(negedge clk);
    checks++;
    if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'h3C}) begin
      errors++;
      $display("FAIL read_data_follow: tx_valid=%b tx_data=%h, required 1/3c", bus.tx_valid, bus.tx_data);
    end
    wait_tx(t0, 2, "read");
    checks++;
    if (tx_q[t0] !== 8'hAA || tx_q[t0+1] !== 8'h3C || we_cnt !== w0) begin
      errors++;
      $display("FAIL read_resp: got %h %h we pulses=%0d, required aa 3c 0", tx_q[t0], tx_q[t0+1], we_cnt - w0);
    end
    $display("read: adr=%h resp=%h %h", bus.adr, tx_q[t0], tx_q[t0+1]);
  endtask

  task automatic test_read_reserved;
    int t0;
    t0 = tx_q.size();
    send_byte(8'h55); send_byte(8'hC1); send_byte(8'h23); send_byte(8'hE4);
    wait_tx(t0, 2, "read_rsv");
    checks++;
    if (tx_q[t0] !== 8'hAA || tx_q[t0+1] !== 8'h86 || bus.adr !== 14'h0123) begin
      errors++;
      $display("FAIL read_rsv: resp %h %h adr=%h, required aa 86 adr=0123", tx_q[t0], tx_q[t0+1], bus.adr);
    end
    $display("read: adr=%h resp=%h %h", bus.adr, tx_q[t0], tx_q[t0+1]);
  endtask

  task automatic test_bad_chk;
    int w0, c0, t0;
    w0 = we_cnt; c0 = chk_cnt; t0 = tx_q.size();
    send_byte(8'h55); send_byte(8'h05); send_byte(8'h12); send_byte(8'h3C); send_byte(8'h00);
    checks++;
    if ({bus.chk_err, bus.tx_valid, bus.tx_data, bus.we} !== {1'b1, 1'b1, 8'hEE, 1'b0}) begin
      errors++;
      $display("FAIL bad_chk_nack: chk_err=%b tx_valid=%b tx_data=%h we=%b, required 1/1/ee/0",
               bus.chk_err, bus.tx_valid, bus.tx_data, bus.we);
    end
    checks++;
    if ({bus.adr, bus.dat_w} !== {14'h0123, 8'h3C}) begin
      errors++;
      $display("FAIL bad_chk_bus: adr=%h dat_w=%h, required 0123/3c", bus.adr, bus.dat_w);
    end
    @(negedge clk);
    checks++;
    if (bus.chk_err !== 1'b0) begin
      errors++;
      $display("FAIL bad_chk_pulse_width: chk_err=%b required 0", bus.chk_err);
    end
    wait_tx(t0, 1, "bad_chk");
    checks++;
    if (tx_q[t0] !== 8'hEE || chk_cnt - c0 !== 1 || we_cnt !== w0) begin
      errors++;
      $display("FAIL bad_chk_resp: resp=%h chk_err pulses=%0d we pulses=%0d, required ee/1/0",
               tx_q[t0], chk_cnt - c0, we_cnt - w0);
    end
    $display("bad_chk: resp=%h chk_err pulses=%0d", tx_q[t0], chk_cnt - c0);
  endtask

  task automatic test_timeout;
    int w0, c0, t0;
    w0 = we_cnt; c0 = chk_cnt; t0 = tx_q.size();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h55); send_byte(8'h05);
    repeat (TO) @(negedge clk);          // TO+1 idle cycles after the last byte
    send_byte(8'h55); send_byte(8'h0A); send_byte(8'h34); send_byte(8'h77); send_byte(8'hB5);
    wait_tx(t0, 1, "timeout");
    checks++;
    if (tx_q[t0] !== 8'hAA || we_cnt - w0 !== 1 || chk_cnt !== c0) begin
      errors++;
      $display("FAIL timeout_resp: resp=%h we pulses=%0d chk_err pulses=%0d, required aa/1/0",
               tx_q[t0], we_cnt - w0, chk_cnt - c0);
    end
    checks++;
    if ({last_adr, last_dw} !== {14'h0A34, 8'h77}) begin
      errors++;
      $display("FAIL timeout_write: adr=%h dat_w=%h, required 0a34/77", last_adr, last_dw);
    end
    $display("timeout: aborted packet dropped, write adr=%h dat_w=%h resp=%h", last_adr, last_dw, tx_q[t0]);
  endtask

  task automatic test_timeout_edge;
    int w0, t0;
    w0 = we_cnt; t0 = tx_q.size();
    // TO-1 idle cycles mid-packet: packet survives.
    send_byte(8'h55); send_byte(8'h05); send_byte(8'h12);
    repeat (TO - 2) @(negedge clk);
    send_byte(8'h3C); send_byte(8'h53);
    // Exactly TO idle cycles mid-packet: packet dropped, fresh packet follows.
    send_byte(8'h55); send_byte(8'h05);
    repeat (TO - 1) @(negedge clk);
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h06);
    wait_tx(t0, 2, "timeout_edge");
    checks++;
    if (tx_q[t0] !== 8'hAA || tx_q[t0+1] !== 8'hAA || we_cnt - w0 !== 2 || {last_adr, last_dw} !== {14'h0102, 8'h03}) begin
      errors++;
      $display("FAIL timeout_edge: resp %h %h we pulses=%0d last adr=%h dat_w=%h, required aa aa/2/0102/03",
               tx_q[t0], tx_q[t0+1], we_cnt - w0, last_adr, last_dw);
    end
    $display("timeout_edge: resp=%h %h we pulses=%0d", tx_q[t0], tx_q[t0+1], we_cnt - w0);
  endtask

  task automatic test_backpressure;
    int t0, k, bad;
    t0 = tx_q.size();
    bus.tx_ready = 1'b0;
    send_byte(8'h55); send_byte(8'h85); send_byte(8'h12); send_byte(8'h97);
    k = 0;
    while (!bus.tx_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({bus.tx_valid, bus.tx_data, bus.rx_ready} !== {1'b1, 8'hAA, 1'b0}) begin
        errors++;
        bad++;
        $display("FAIL backpressure_hold: cycle %0d tx_valid=%b tx_data=%h rx_ready=%b, required 1/aa/0",
                 i, bus.tx_valid, bus.tx_data, bus.rx_ready);
      end
      @(negedge clk);
    end
    bus.tx_ready = 1'b1;
    wait_tx(t0, 2, "backpressure");
    checks++;
    if (tx_q[t0] !== 8'hAA || tx_q[t0+1] !== 8'h3C) begin
      errors++;
      $display("FAIL backpressure_order: got %h %h, required aa 3c", tx_q[t0], tx_q[t0+1]);
    end
    $display("backpressure: held %0d cycles (%0d bad), resp=%h %h", 10, bad, tx_q[t0], tx_q[t0+1]);
  endtask

  task automatic test_reset_mid;
    int w0, t0;
    send_byte(8'h55); send_byte(8'h05); send_byte(8'h12);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.adr, bus.we, bus.dat_w, bus.tx_valid, bus.tx_data, bus.chk_err, bus.rx_ready} !== 34'h0) begin
      errors++;
      $display("FAIL reset_mid_values: adr=%h we=%b dat_w=%h tx_valid=%b tx_data=%h chk_err=%b rx_ready=%b, required all 0",
               bus.adr, bus.we, bus.dat_w, bus.tx_valid, bus.tx_data, bus.chk_err, bus.rx_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    w0 = we_cnt; t0 = tx_q.size();
    send_byte(8'h55); send_byte(8'h05); send_byte(8'h12); send_byte(8'h3C); send_byte(8'h53);
    wait_tx(t0, 1, "reset_mid");
    checks++;
    if (tx_q[t0] !== 8'hAA || we_cnt - w0 !== 1 || {last_adr, last_dw} !== {14'h0512, 8'h3C}) begin
      errors++;
      $display("FAIL reset_mid_write: resp=%h we pulses=%0d adr=%h dat_w=%h, required aa/1/0512/3c",
               tx_q[t0], we_cnt - w0, last_adr, last_dw);
    end
    $display("reset_mid: partial packet dropped, write adr=%h resp=%h", last_adr, tx_q[t0]);
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b1;
    test_reset;
    test_write;
    test_read;
    test_read_reserved;
    test_bad_chk;
    test_timeout;
    test_timeout_edge;
    test_backpressure;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
